// File: rtl/parking_lot_manager.sv
// -----------------------------------------------------------------------------
// parking_lot_manager
//
// Purpose
//   Tracks university and free-class occupancy of a single parking lot against
//   a time-of-day free-space schedule. Entry and exit gates each run a
//   req/ack handshake and answer every request with an explicit grant or
//   reject. The occupancy and vacancy outputs drive the gate signage and the
//   lot display.
//
// Parameters
//   TOTAL_SPACES     total bays in the lot
//   FREE_CAP_MIN     free-class capacity during the day window
//   FREE_CAP_MAX     free-class capacity outside the day and ramp windows
//   DAY_START_HOUR   first hour of the day window, also the hour after reset
//   RAMP_START_HOUR  first ramp hour (day window ends the hour before)
//   RAMP_HOURS       number of ramp hours
//   RAMP_STEP        free-capacity increment per ramp hour
//   CLOCKS_PER_HOUR  clk cycles per simulated hour
//   CNT_W            counter width, derived from TOTAL_SPACES
//
// Ports
//   clk, rst                      rising-edge clock, async active-high reset
//   entry_req / entry_is_uni      entry request (level) and class of the car
//   exit_req  / exit_is_uni       exit request (level) and class of the car
//   entry_ack / entry_granted     1-cycle decision pulse, 1 = gate opens
//   exit_ack  / exit_granted      1-cycle decision pulse, 0 = count was zero
//   uni_parked / free_parked      cars parked per class
//   uni_vacant / free_vacant      spaces available per class (1-cycle lag)
//   uni_avail  / free_avail       vacancy non-zero flags
//   hour                          current hour 0..23
//   free_cap                      current free-class capacity
// -----------------------------------------------------------------------------
module parking_lot_manager #(
   parameter int TOTAL_SPACES    = 700,
   parameter int FREE_CAP_MIN    = 200,
   parameter int FREE_CAP_MAX    = 500,
   parameter int DAY_START_HOUR  = 8,
   parameter int RAMP_START_HOUR = 13,
   parameter int RAMP_HOURS      = 3,
   parameter int RAMP_STEP       = 50,
   parameter int CLOCKS_PER_HOUR = 100,
   localparam int CNT_W          = $clog2(TOTAL_SPACES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             entry_req,
   input  logic             entry_is_uni,
   input  logic             exit_req,
   input  logic             exit_is_uni,
   output logic             entry_ack,
   output logic             entry_granted,
   output logic             exit_ack,
   output logic             exit_granted,
   output logic [CNT_W-1:0] uni_parked,
   output logic [CNT_W-1:0] free_parked,
   output logic [CNT_W-1:0] uni_vacant,
   output logic [CNT_W-1:0] free_vacant,
   output logic             uni_avail,
   output logic             free_avail,
   output logic [4:0]       hour,
   output logic [CNT_W-1:0] free_cap
);

   // ---------------------------------------------------------------------------
   // Constants sized to the registers they are compared with or loaded into
   // ---------------------------------------------------------------------------
   localparam int CYC_W = (CLOCKS_PER_HOUR > 1) ? $clog2(CLOCKS_PER_HOUR) : 1;

   localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(CLOCKS_PER_HOUR - 1);
   localparam logic [4:0]       HOUR_LAST  = 5'd23;
   localparam logic [4:0]       DAY_H      = 5'(DAY_START_HOUR);
   localparam logic [4:0]       RAMP_H     = 5'(RAMP_START_HOUR);
   localparam logic [4:0]       RAMP_END_H = 5'(RAMP_START_HOUR + RAMP_HOURS);

   localparam logic [CNT_W-1:0] TOTAL_C    = CNT_W'(TOTAL_SPACES);
   localparam logic [CNT_W-1:0] CAP_MIN_C  = CNT_W'(FREE_CAP_MIN);
   localparam logic [CNT_W-1:0] CAP_MAX_C  = CNT_W'(FREE_CAP_MAX);
   localparam logic [CNT_W-1:0] STEP_C     = CNT_W'(RAMP_STEP);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DECIDE,
      S_ACK,
      S_WAIT_LOW
   } gate_state_t;

   // a - b, clamped at zero instead of wrapping
   function automatic logic [CNT_W-1:0] sat_sub(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      return (a > b) ? (a - b) : '0;
   endfunction

   function automatic logic [CNT_W-1:0] min2(input logic [CNT_W-1:0] a,
                                             input logic [CNT_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

   // ---------------------------------------------------------------------------
   // Registers and wires
   // ---------------------------------------------------------------------------
   logic [CYC_W-1:0] r_cyc;
   logic [4:0]       r_hour;
   logic [CNT_W-1:0] r_free_cap;
   logic [CNT_W-1:0] r_uni_parked;
   logic [CNT_W-1:0] r_free_parked;
   logic [CNT_W-1:0] r_uni_vacant;
   logic [CNT_W-1:0] r_free_vacant;

   gate_state_t      r_entry_state;
   logic             r_entry_uni;
   logic             r_entry_ack;
   logic             r_entry_granted;

   gate_state_t      r_exit_state;
   logic             r_exit_uni;
   logic             r_exit_ack;
   logic             r_exit_granted;

   logic [4:0]       w_ramp_idx;
   logic [CNT_W-1:0] w_free_cap_next;
   logic [CNT_W-1:0] w_uni_cap;
   logic [CNT_W-1:0] w_tot_vac;
   logic [CNT_W-1:0] w_uni_vac;
   logic [CNT_W-1:0] w_free_vac;
   logic             w_entry_grant;
   logic             w_exit_grant;
   logic             w_entry_fire;
   logic             w_exit_fire;
   logic             w_uni_inc;
   logic             w_uni_dec;
   logic             w_free_inc;
   logic             w_free_dec;

   // ---------------------------------------------------------------------------
   // Timebase: cycle counter wraps once per simulated hour, hour wraps 23 -> 0
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is written with <= so every flop samples the values
   // from before the edge, independent of the order of statements.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cyc  <= '0;
         r_hour <= DAY_H;
      end else if (r_cyc == CYC_LAST) begin
         r_cyc  <= '0;
         r_hour <= (r_hour == HOUR_LAST) ? 5'd0 : r_hour + 5'd1;
      end else begin
         r_cyc  <= r_cyc + CYC_W'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Free-class capacity schedule, decoded from the current hour
   // ---------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_free_cap_next = CAP_MAX_C;
      w_ramp_idx      = r_hour - RAMP_H + 5'd1;
      if (r_hour >= DAY_H && r_hour < RAMP_H) begin
         w_free_cap_next = CAP_MIN_C;
      end else if (r_hour >= RAMP_H && r_hour < RAMP_END_H) begin
         w_free_cap_next = CAP_MIN_C + CNT_W'(w_ramp_idx) * STEP_C;
      end
   end

   // ---------------------------------------------------------------------------
   // Vacancy from the current registers. A shrinking capacity can leave a class
   // over its cap; its vacancy then reads zero and no cars are evicted.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_uni_cap  = TOTAL_C - r_free_cap;
      w_tot_vac  = sat_sub(TOTAL_C, r_uni_parked + r_free_parked);
      w_uni_vac  = min2(sat_sub(w_uni_cap,  r_uni_parked),  w_tot_vac);
      w_free_vac = min2(sat_sub(r_free_cap, r_free_parked), w_tot_vac);
   end

   // Entry is judged on pre-exit counts, so a same-cycle exit never makes room
   // for the entry it races with.
   always_comb begin
      w_entry_grant = r_entry_uni ? (w_uni_vac != '0) : (w_free_vac != '0);
      w_exit_grant  = r_exit_uni  ? (r_uni_parked != '0) : (r_free_parked != '0);
      w_entry_fire  = (r_entry_state == S_DECIDE) && w_entry_grant;
      w_exit_fire   = (r_exit_state  == S_DECIDE) && w_exit_grant;
      w_uni_inc     = w_entry_fire &&  r_entry_uni;
      w_free_inc    = w_entry_fire && !r_entry_uni;
      w_uni_dec     = w_exit_fire  &&  r_exit_uni;
      w_free_dec    = w_exit_fire  && !r_exit_uni;
   end

   // ---------------------------------------------------------------------------
   // Occupancy counters; a same-class entry and exit in one cycle net to zero
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_uni_parked  <= '0;
         r_free_parked <= '0;
      end else begin
         r_uni_parked  <= r_uni_parked  + CNT_W'(w_uni_inc)  - CNT_W'(w_uni_dec);
         r_free_parked <= r_free_parked + CNT_W'(w_free_inc) - CNT_W'(w_free_dec);
      end
   end

   // Schedule and display values, registered one cycle behind their sources
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_free_cap    <= CAP_MIN_C;
         r_uni_vacant  <= TOTAL_C - CAP_MIN_C;
         r_free_vacant <= CAP_MIN_C;
      end else begin
         r_free_cap    <= w_free_cap_next;
         r_uni_vacant  <= w_uni_vac;
         r_free_vacant <= w_free_vac;
      end
   end

   // ---------------------------------------------------------------------------
   // Entry gate handshake. WAIT_LOW swallows a held request so each request
   // is counted exactly once.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_entry_state   <= S_IDLE;
         r_entry_uni     <= 1'b0;
         r_entry_ack     <= 1'b0;
         r_entry_granted <= 1'b0;
      end else begin
         case (r_entry_state)
            S_IDLE: begin
               if (entry_req) begin
                  r_entry_uni   <= entry_is_uni;
                  r_entry_state <= S_DECIDE;
               end
            end
            S_DECIDE: begin
               r_entry_ack     <= 1'b1;
               r_entry_granted <= w_entry_grant;
               r_entry_state   <= S_ACK;
            end
            S_ACK: begin
               r_entry_ack     <= 1'b0;
               r_entry_granted <= 1'b0;
               r_entry_state   <= S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
               if (!entry_req) r_entry_state <= S_IDLE;
            end
            default: r_entry_state <= S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Exit gate handshake, same sequence; granted only if the class is non-empty
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_exit_state   <= S_IDLE;
         r_exit_uni     <= 1'b0;
         r_exit_ack     <= 1'b0;
         r_exit_granted <= 1'b0;
      end else begin
         case (r_exit_state)
            S_IDLE: begin
               if (exit_req) begin
                  r_exit_uni   <= exit_is_uni;
                  r_exit_state <= S_DECIDE;
               end
            end
            S_DECIDE: begin
               r_exit_ack     <= 1'b1;
               r_exit_granted <= w_exit_grant;
               r_exit_state   <= S_ACK;
            end
            S_ACK: begin
               r_exit_ack     <= 1'b0;
               r_exit_granted <= 1'b0;
               r_exit_state   <= S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
               if (!exit_req) r_exit_state <= S_IDLE;
            end
            default: r_exit_state <= S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign entry_ack     = r_entry_ack;
   assign entry_granted = r_entry_granted;
   assign exit_ack      = r_exit_ack;
   assign exit_granted  = r_exit_granted;
   assign uni_parked    = r_uni_parked;
   assign free_parked   = r_free_parked;
   assign uni_vacant    = r_uni_vacant;
   assign free_vacant   = r_free_vacant;
   assign uni_avail     = (r_uni_vacant  != '0);
   assign free_avail    = (r_free_vacant != '0);
   assign hour          = r_hour;
   assign free_cap      = r_free_cap;

endmodule

// File: tb/tb_parking_lot_manager.sv
// -----------------------------------------------------------------------------
// tb_parking_lot_manager
//
// Directed bench for parking_lot_manager with hand-computed expectations.
// The hour length is stretched so a 200-car fill fits inside one hour.
// -----------------------------------------------------------------------------
module tb_parking_lot_manager;

   localparam int CPH   = 1000;
   localparam int CNT_W = $clog2(700 + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             entry_req = 1'b0;
   logic             entry_is_uni = 1'b0;
   logic             exit_req = 1'b0;
   logic             exit_is_uni = 1'b0;
   logic             entry_ack;
   logic             entry_granted;
   logic             exit_ack;
   logic             exit_granted;
   logic [CNT_W-1:0] uni_parked;
   logic [CNT_W-1:0] free_parked;
   logic [CNT_W-1:0] uni_vacant;
   logic [CNT_W-1:0] free_vacant;
   logic             uni_avail;
   logic             free_avail;
   logic [4:0]       hour;
   logic [CNT_W-1:0] free_cap;

   int n_checks = 0;
   int n_fail   = 0;

   parking_lot_manager #(.CLOCKS_PER_HOUR(CPH)) dut (
      .clk           (clk),
      .rst           (rst),
      .entry_req     (entry_req),
      .entry_is_uni  (entry_is_uni),
      .exit_req      (exit_req),
      .exit_is_uni   (exit_is_uni),
      .entry_ack     (entry_ack),
      .entry_granted (entry_granted),
      .exit_ack      (exit_ack),
      .exit_granted  (exit_granted),
      .uni_parked    (uni_parked),
      .free_parked   (free_parked),
      .uni_vacant    (uni_vacant),
      .free_vacant   (free_vacant),
      .uni_avail     (uni_avail),
      .free_avail    (free_avail),
      .hour          (hour),
      .free_cap      (free_cap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reset applied and released on falling edges; request lines left as they are
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // One handshake on either or both gates, starting on a falling edge.
   // Returns grants and request-to-ack latency (-1 if no ack within 8 cycles).
   // Ends on the falling edge after the gates are back in IDLE.
   task automatic gate_txn(input logic en_e, input logic e_uni,
                           input logic en_x, input logic x_uni,
                           output logic e_gr, output logic x_gr,
                           output int e_lat, output int x_lat);
      int n;
      e_gr = 1'b0; x_gr = 1'b0; e_lat = -1; x_lat = -1;
      entry_is_uni = e_uni; exit_is_uni = x_uni;
      entry_req = en_e; exit_req = en_x;
      n = 0;
      while (((en_e && e_lat < 0) || (en_x && x_lat < 0)) && n < 8) begin
         @(posedge clk); #1;
         n++;
         if (entry_ack && e_lat < 0) begin e_lat = n; e_gr = entry_granted; end
         if (exit_ack  && x_lat < 0) begin x_lat = n; x_gr = exit_granted;  end
      end
      @(negedge clk);
      entry_req = 1'b0; exit_req = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // Repeated single-gate transactions; counts grants and correct latencies
   task automatic bulk(input logic is_entry, input logic uni, input int count,
                       output int grants, output int good_lat);
      logic eg, xg;
      int   el, xl;
      grants = 0; good_lat = 0;
      for (int i = 0; i < count; i++) begin
         gate_txn(is_entry, uni, !is_entry, uni, eg, xg, el, xl);
         if (is_entry ? eg : xg) grants++;
         if ((is_entry ? el : xl) == 2) good_lat++;
      end
   endtask

   // Poll each cycle until the hour reads h; n is the number of edges waited
   task automatic wait_hour(input logic [4:0] h, input string tag, output int n);
      n = 0;
      while (hour !== h && n < 25 * CPH) begin
         @(posedge clk); #1;
         n++;
      end
      check(tag, hour, h);
   endtask

   // Let the registered schedule and then the vacancy catch up
   task automatic settle();
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic eg, xg;
      int   el, xl, n, acks, grants, good;

      // ---------------- reset state ----------------
      do_reset();
      check("rst_hour",        hour, 8);
      check("rst_free_cap",    free_cap, 200);
      check("rst_uni_vacant",  uni_vacant, 500);
      check("rst_free_vacant", free_vacant, 200);
      check("rst_uni_parked",  uni_parked, 0);
      check("rst_free_parked", free_parked, 0);
      check("rst_avail",       {uni_avail, free_avail}, 2'b11);
      check("rst_acks",        {entry_ack, entry_granted, exit_ack, exit_granted}, 4'b0000);

      // ---------------- T1: single uni entry, exact timing ----------------
      entry_is_uni = 1'b1; entry_req = 1'b1;
      @(posedge clk); #1;
      check("t1_ack_early", entry_ack, 0);
      @(posedge clk); #1;
      check("t1_ack",        entry_ack, 1);
      check("t1_granted",    entry_granted, 1);
      check("t1_uni_parked", uni_parked, 1);
      @(posedge clk); #1;
      check("t1_ack_pulse",  entry_ack, 0);
      check("t1_uni_vacant", uni_vacant, 499);
      check("t1_free_vac",   free_vacant, 200);
      @(negedge clk); entry_req = 1'b0;
      repeat (2) @(negedge clk);

      // ---------------- T5: exits on an empty class, held request ----------------
      gate_txn(1'b0, 1'b0, 1'b1, 1'b1, eg, xg, el, xl);
      check("t5_exit_lat",     xl, 2);
      check("t5_exit_granted", xg, 1);
      check("t5_uni_parked",   uni_parked, 0);
      gate_txn(1'b0, 1'b0, 1'b1, 1'b1, eg, xg, el, xl);
      check("t5_empty_lat",     xl, 2);
      check("t5_empty_granted", xg, 0);
      check("t5_empty_counts",  {22'd0, uni_parked}, 0);
      gate_txn(1'b0, 1'b0, 1'b1, 1'b0, eg, xg, el, xl);
      check("t5_free_empty_granted", xg, 0);
      check("t5_free_empty_count",   free_parked, 0);

      exit_is_uni = 1'b1; exit_req = 1'b1; acks = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (exit_ack) acks++;
      end
      check("t5_held_exit_acks", acks, 1);
      check("t5_held_exit_cnt",  uni_parked, 0);
      @(negedge clk); exit_req = 1'b0;
      repeat (2) @(negedge clk);

      entry_is_uni = 1'b0; entry_req = 1'b1; acks = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (entry_ack) acks++;
      end
      check("held_entry_acks", acks, 1);
      check("held_entry_cnt",  free_parked, 1);
      @(negedge clk); entry_req = 1'b0;
      repeat (2) @(negedge clk);

      // ---------------- reset in the middle of a handshake ----------------
      entry_is_uni = 1'b1; entry_req = 1'b1;
      @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      check("mid_rst_ack",        entry_ack, 0);
      check("mid_rst_free_count", free_parked, 0);
      check("mid_rst_uni_count",  uni_parked, 0);
      rst = 1'b0;
      n = 0;
      while (!entry_ack && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      check("mid_rst_relat",   n, 2);
      check("mid_rst_granted", entry_granted, 1);
      check("mid_rst_uni",     uni_parked, 1);
      @(negedge clk); entry_req = 1'b0;
      repeat (2) @(negedge clk);

      // ---------------- T2: free class full at hour 8 ----------------
      do_reset();
      bulk(1'b1, 1'b0, 200, grants, good);
      check("t2_fill_grants", grants, 200);
      check("t2_fill_lat",    good, 200);
      check("t2_hour",        hour, 8);
      check("t2_free_parked", free_parked, 200);
      check("t2_free_vacant", free_vacant, 0);
      check("t2_free_avail",  free_avail, 0);
      check("t2_uni_vacant",  uni_vacant, 500);
      gate_txn(1'b1, 1'b0, 1'b0, 1'b0, eg, xg, el, xl);
      check("t2_reject_lat",     el, 2);
      check("t2_reject_granted", eg, 0);
      check("t2_reject_count",   free_parked, 200);
      gate_txn(1'b1, 1'b1, 1'b0, 1'b0, eg, xg, el, xl);
      check("t2_uni_granted", eg, 1);
      check("t2_uni_vacant2", uni_vacant, 499);

      // ---------------- T3/T4: schedule, wrap, capacity shrink ----------------
      do_reset();
      wait_hour(5'd9, "t3_reach_9", n);
      check("t3_hour_len", n, CPH);
      wait_hour(5'd12, "t3_reach_12", n);
      settle();
      check("t3_cap_12", free_cap, 200);
      wait_hour(5'd13, "t3_reach_13", n);
      settle();
      check("t3_cap_13",       free_cap, 250);
      check("t3_free_vac_13",  free_vacant, 250);
      check("t3_uni_vac_13",   uni_vacant, 450);
      wait_hour(5'd14, "t3_reach_14", n);
      settle();
      check("t3_cap_14", free_cap, 300);
      wait_hour(5'd15, "t3_reach_15", n);
      settle();
      check("t3_cap_15", free_cap, 350);
      wait_hour(5'd16, "t3_reach_16", n);
      settle();
      check("t3_cap_16", free_cap, 500);

      bulk(1'b1, 1'b0, 400, grants, good);
      check("t4_fill_grants", grants, 400);
      check("t4_free_parked", free_parked, 400);
      check("t4_free_vacant", free_vacant, 100);
      check("t4_uni_vacant",  uni_vacant, 200);

      wait_hour(5'd23, "t3_reach_23", n);
      wait_hour(5'd0,  "t3_wrap_0", n);
      check("t3_wrap_len", n, CPH);
      settle();
      check("t3_cap_0", free_cap, 500);
      wait_hour(5'd8, "t3_reach_8", n);
      settle();
      check("t4_cap_8",         free_cap, 200);
      check("t4_no_evict",      free_parked, 400);
      check("t4_free_vacant_0", free_vacant, 0);
      check("t4_free_avail_0",  free_avail, 0);
      check("t4_uni_vacant_8",  uni_vacant, 300);

      bulk(1'b0, 1'b0, 199, grants, good);
      check("t4_exit_grants", grants, 199);
      check("t4_parked_201",  free_parked, 201);
      check("t4_vac_at_201",  free_vacant, 0);
      gate_txn(1'b0, 1'b0, 1'b1, 1'b0, eg, xg, el, xl);
      check("t4_parked_200",  free_parked, 200);
      check("t4_vac_at_200",  free_vacant, 0);
      gate_txn(1'b0, 1'b0, 1'b1, 1'b0, eg, xg, el, xl);
      check("t4_parked_199",  free_parked, 199);
      check("t4_vac_at_199",  free_vacant, 1);
      check("t4_avail_199",   free_avail, 1);

      // ---------------- T6: simultaneous entry and exit, uni full ----------------
      do_reset();
      bulk(1'b1, 1'b1, 500, grants, good);
      check("t6_fill_grants", grants, 500);
      check("t6_uni_parked",  uni_parked, 500);
      check("t6_uni_vacant",  uni_vacant, 0);
      check("t6_uni_avail",   uni_avail, 0);
      check("t6_free_vacant", free_vacant, 200);
      gate_txn(1'b1, 1'b1, 1'b1, 1'b1, eg, xg, el, xl);
      check("t6_entry_lat",     el, 2);
      check("t6_exit_lat",      xl, 2);
      check("t6_entry_granted", eg, 0);
      check("t6_exit_granted",  xg, 1);
      check("t6_uni_499",       uni_parked, 499);
      check("t6_uni_vac_1",     uni_vacant, 1);
      gate_txn(1'b1, 1'b1, 1'b1, 1'b1, eg, xg, el, xl);
      check("t6_net_entry_gr",  eg, 1);
      check("t6_net_exit_gr",   xg, 1);
      check("t6_net_zero",      uni_parked, 499);
      gate_txn(1'b1, 1'b0, 1'b1, 1'b1, eg, xg, el, xl);
      check("t6_mixed_entry",   eg, 1);
      check("t6_mixed_exit",    xg, 1);
      check("t6_mixed_counts",  {uni_parked, free_parked}, {10'd498, 10'd1});

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
